// File: rtl/shift_reg_arb_if.sv
// Requester handshake and pipeline output bus for shift_reg_arb.
// master = producer/consumer side, slave = the arbiter.
interface shift_reg_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [ID_W-1:0]               out_id;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output out_valid,
    output out_data,
    output out_id
  );
endinterface

// File: rtl/shift_reg_arb.sv
// Arbitrated, fixed-latency shared shift pipeline with in-flight tracking and drain.
// Optional macro SHIFT_REG_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module shift_reg_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int NUM_REGS   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_reg_arb_if.slave       bus,
  input  logic                 drain,
  output logic                 busy,
  output logic                 drain_done
);
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W  = $clog2(NUM_REGS + 1);
  localparam int PIPE_W = 1 + ID_W + DATA_WIDTH;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  busy_q, busy_d;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_id;
  logic                  accept;
  logic                  admit_en;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [PIPE_W-1:0]     pipe_in;
  logic [PIPE_W-1:0]     pipe_out;

  // Drain masks admission combinationally in the very cycle it is sampled.
  assign admit_en = (state_q == ST_RUN) && !drain;

`ifdef SHIFT_REG_ARB_FIXED_PRIO_EN
  always_comb begin
    grant    = '0;
    grant_id = '0;
    accept   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (admit_en && !accept && bus.req_valid[i]) begin
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
        accept   = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;
  int              idx;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    accept   = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (admit_en && !accept && bus.req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        accept     = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    grant_data = '0;
    if (accept) begin
      grant_data = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign pipe_in       = accept ? {1'b1, grant_id, grant_data} : '0;
  assign bus.req_ready = grant;

  shift_reg #(
    .WIDTH (PIPE_W),
    .DEPTH (NUM_REGS)
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .d   (pipe_in),
    .q   (pipe_out)
  );

  assign {bus.out_valid, bus.out_id, bus.out_data} = pipe_out;

  always_comb begin
    count_d = count_q;
    case ({accept, bus.out_valid})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    busy_d = (count_d != '0);
  end

  // DRAIN may finish while the last word is still on the output this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((count_q == '0) || ((count_q == CNT_W'(1)) && bus.out_valid)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = drain ? ST_HOLD : ST_RUN;
      end
      default: begin
        if (!drain) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign drain_done = (state_q == ST_DONE);

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));
  a_count_bound:  assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(NUM_REGS));
endmodule

// Plain DEPTH-stage delay line with synchronous clear; no enable, so it never stalls.
module shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[DEPTH-1];
endmodule

// File: tb/tb_shift_reg_arb.sv
// Self-checking bench for shift_reg_arb: cycle-indexed reference model plus directed pins.
// Honours SHIFT_REG_ARB_FIXED_PRIO_EN the same way the design does.
module tb_shift_reg_arb;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_REQ    = 4;
  localparam int NUM_REGS   = 10;
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW_ALL     = NUM_REQ * DATA_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic drain;
  logic busy;
  logic drain_done;

  int checks = 0;
  int errors = 0;

  shift_reg_arb_if #(.DATA_WIDTH(DATA_WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  shift_reg_arb #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REQ    (NUM_REQ),
    .NUM_REGS   (NUM_REGS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .drain      (drain),
    .busy       (busy),
    .drain_done (drain_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Model: words are scheduled by the cycle they must appear; admission is free,
  // waiting for a computed completion cycle, or held until drain drops.
  bit                    check_en = 1'b0;
  int                    cyc;
  int                    ptr;
  int                    mode;
  int                    done_cyc;
  int                    due_q[$];
  logic [DATA_WIDTH-1:0] sched_data[int];
  int                    sched_id[int];

  logic [NUM_REQ-1:0]    ready_log[int];
  logic                  outv_log[int];
  logic [DATA_WIDTH-1:0] outd_log[int];
  logic [ID_W-1:0]       outid_log[int];
  logic                  busy_log[int];
  logic                  done_log[int];

  int                    gid;
  logic [NUM_REQ-1:0]    exp_ready;
  logic                  exp_v;
  logic [DATA_WIDTH-1:0] exp_d;
  int                    exp_id;
  logic                  exp_done;
  logic                  exp_busy;

  always @(negedge clk) begin
    if (check_en) begin
      gid = -1;
      if (mode == 0 && !drain) begin
`ifdef SHIFT_REG_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++)
          if (gid < 0 && bus.req_valid[i]) gid = i;
`else
        for (int k = 1; k <= NUM_REQ; k++)
          if (gid < 0 && bus.req_valid[(ptr + k) % NUM_REQ]) gid = (ptr + k) % NUM_REQ;
`endif
      end
      exp_ready = '0;
      if (gid >= 0) exp_ready[gid] = 1'b1;
      exp_v    = sched_data.exists(cyc);
      exp_d    = exp_v ? sched_data[cyc] : '0;
      exp_id   = exp_v ? sched_id[cyc] : 0;
      exp_busy = (due_q.size() != 0);
      exp_done = (mode == 1) && (cyc == done_cyc);

      checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      checkOutput("out_valid", 64'(bus.out_valid), 64'(exp_v));
      checkOutput("out_data", 64'(bus.out_data), 64'(exp_d));
      checkOutput("out_id", 64'(bus.out_id), 64'(exp_id));
      checkOutput("busy", 64'(busy), 64'(exp_busy));
      checkOutput("drain_done", 64'(drain_done), 64'(exp_done));

      ready_log[cyc] = bus.req_ready;
      outv_log[cyc]  = bus.out_valid;
      outd_log[cyc]  = bus.out_data;
      outid_log[cyc] = bus.out_id;
      busy_log[cyc]  = busy;
      done_log[cyc]  = drain_done;

      if (rst) begin
        due_q.delete();
        sched_data.delete();
        sched_id.delete();
        ptr  = NUM_REQ - 1;
        mode = 0;
      end else begin
        if (gid >= 0) begin
          due_q.push_back(cyc + NUM_REGS);
          sched_data[cyc + NUM_REGS] = bus.req_data[gid*DATA_WIDTH +: DATA_WIDTH];
          sched_id[cyc + NUM_REGS]   = gid;
          ptr = gid;
        end
        if (mode == 0 && drain) begin
          mode     = 1;
          done_cyc = cyc + 2;
          foreach (due_q[i]) if (due_q[i] + 1 > done_cyc) done_cyc = due_q[i] + 1;
        end else if (mode == 1 && cyc == done_cyc) begin
          mode = drain ? 2 : 0;
        end else if (mode == 2 && !drain) begin
          mode = 0;
        end
        while (due_q.size() > 0 && due_q[0] <= cyc) void'(due_q.pop_front());
        if (sched_data.exists(cyc)) begin
          sched_data.delete(cyc);
          sched_id.delete(cyc);
        end
      end
      cyc++;
    end
  end

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [DW_ALL-1:0] d,
                               input logic dr, input logic r);
    bus.req_valid = v;
    bus.req_data  = d;
    drain         = dr;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW_ALL-1:0] slot(input int i, input logic [DATA_WIDTH-1:0] val);
    logic [DW_ALL-1:0] r;
    r = '0;
    r[i*DATA_WIDTH +: DATA_WIDTH] = val;
    return r;
  endfunction

  int                 t;
  int                 drain_left;
  logic [DW_ALL-1:0]  all_d;
  logic [NUM_REQ-1:0] rv;
  logic [DW_ALL-1:0]  rd;
  logic               rr;
  logic [NUM_REQ-1:0] exp_g;
  int                 exp_i;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    drain         = 1'b0;
    rst           = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc      = 0;
    ptr      = NUM_REQ - 1;
    mode     = 0;
    done_cyc = 0;
    check_en = 1'b1;

    applyStimulus('0, '0, 1'b0, 1'b1);
    checkOutput("reset_out_valid", 64'(outv_log[0]), 64'd0);
    checkOutput("reset_busy", 64'(busy_log[0]), 64'd0);
    checkOutput("reset_drain_done", 64'(done_log[0]), 64'd0);

    // Single word from requester 2.
    t = cyc;
    applyStimulus(4'b0100, slot(2, 8'h5A), 1'b0, 1'b0);
    repeat (13) applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("single_out_valid_early", 64'(outv_log[t+9]), 64'd0);
    checkOutput("single_out_valid", 64'(outv_log[t+10]), 64'd1);
    checkOutput("single_out_data", 64'(outd_log[t+10]), 64'h5A);
    checkOutput("single_out_id", 64'(outid_log[t+10]), 64'd2);
    checkOutput("single_busy_first", 64'(busy_log[t+1]), 64'd1);
    checkOutput("single_busy_last", 64'(busy_log[t+10]), 64'd1);
    checkOutput("single_busy_clear", 64'(busy_log[t+11]), 64'd0);

    // All four requesters for eight cycles, starting from reset priority.
    applyStimulus('0, '0, 1'b0, 1'b1);
    all_d = '0;
    for (int i = 0; i < NUM_REQ; i++) all_d = all_d | slot(i, 8'(16 + i));
    t = cyc;
    repeat (8) applyStimulus(4'b1111, all_d, 1'b0, 1'b0);
    repeat (12) applyStimulus('0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
`ifdef SHIFT_REG_ARB_FIXED_PRIO_EN
      exp_i = 0;
`else
      exp_i = k % NUM_REQ;
`endif
      exp_g = '0;
      exp_g[exp_i] = 1'b1;
      checkOutput($sformatf("all_grant_%0d", k), 64'(ready_log[t+k]), 64'(exp_g));
      checkOutput($sformatf("all_out_id_%0d", k), 64'(outid_log[t+10+k]), 64'(exp_i));
      checkOutput($sformatf("all_out_data_%0d", k), 64'(outd_log[t+10+k]), 64'(16 + exp_i));
    end

    // Requesters 1 and 3 only.
    t = cyc;
    repeat (6) applyStimulus(4'b1010, slot(1, 8'hA1) | slot(3, 8'hA3), 1'b0, 1'b0);
    repeat (12) applyStimulus('0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
`ifdef SHIFT_REG_ARB_FIXED_PRIO_EN
      exp_g = 4'b0010;
`else
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      checkOutput($sformatf("pair_grant_%0d", k), 64'(ready_log[t+k]), 64'(exp_g));
    end

    // Drain raised at cycle 2 while requester 0 streams.
    t = cyc;
    for (int k = 0; k < 18; k++)
      applyStimulus(4'b0001, slot(0, 8'(k)), (k >= 2 && k <= 14), 1'b0);
    repeat (14) applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("drain_grant_c1", 64'(ready_log[t+1]), 64'd1);
    checkOutput("drain_grant_c2", 64'(ready_log[t+2]), 64'd0);
    checkOutput("drain_last_out", 64'(outv_log[t+11]), 64'd1);
    checkOutput("drain_no_out", 64'(outv_log[t+12]), 64'd0);
    checkOutput("drain_done_c11", 64'(done_log[t+11]), 64'd0);
    checkOutput("drain_done_c12", 64'(done_log[t+12]), 64'd1);
    checkOutput("drain_done_c13", 64'(done_log[t+13]), 64'd0);
    checkOutput("drain_hold_grant", 64'(ready_log[t+15]), 64'd0);
    checkOutput("drain_resume_grant", 64'(ready_log[t+16]), 64'd1);

    // One-cycle drain with an empty pipeline.
    t = cyc;
    for (int k = 0; k < 5; k++) applyStimulus(4'b0001, slot(0, 8'hC0), (k == 0), 1'b0);
    repeat (12) applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("pulse_masked", 64'(ready_log[t]), 64'd0);
    checkOutput("pulse_done_c1", 64'(done_log[t+1]), 64'd0);
    checkOutput("pulse_done_c2", 64'(done_log[t+2]), 64'd1);
    checkOutput("pulse_grant_c2", 64'(ready_log[t+2]), 64'd0);
    checkOutput("pulse_grant_c3", 64'(ready_log[t+3]), 64'd1);

    // Reset in the middle of five in-flight words.
    t = cyc;
    for (int k = 0; k < 5; k++) applyStimulus(4'b0100, slot(2, 8'(8'h30 + k)), 1'b0, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b1);
    applyStimulus(4'b1111, all_d, 1'b0, 1'b0);
    repeat (14) applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("rst_busy_before", 64'(busy_log[t+5]), 64'd1);
    checkOutput("rst_busy_after", 64'(busy_log[t+6]), 64'd0);
    checkOutput("rst_first_grant", 64'(ready_log[t+6]), 64'd1);
    for (int k = 10; k < 15; k++)
      checkOutput($sformatf("rst_discard_%0d", k), 64'(outv_log[t+k]), 64'd0);
    checkOutput("rst_new_out_valid", 64'(outv_log[t+16]), 64'd1);
    checkOutput("rst_new_out_id", 64'(outid_log[t+16]), 64'd0);

    // Randomized traffic with occasional drain bursts and resets.
    drain_left = 0;
    for (int n = 0; n < 1500; n++) begin
      if (drain_left == 0 && $urandom_range(0, 24) == 0) drain_left = $urandom_range(1, 20);
      rv = NUM_REQ'($urandom);
      if (n % 300 >= 150) rv = rv & NUM_REQ'($urandom);
      rd = DW_ALL'($urandom);
      rr = ($urandom_range(0, 249) == 0);
      applyStimulus(rv, rd, drain_left != 0, rr);
      if (drain_left > 0) drain_left--;
    end
    repeat (15) applyStimulus('0, '0, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_reg_arb.md
Name: shift_reg_arb

Overview:
- Shares one fixed-latency shift pipeline (built from the team's shift_reg utility) among NUM_REQ requesters.
- Round-robin arbiter admits at most one word per cycle and tags it with the requester ID.
- Tracks in-flight words and supports a drain sequence that stops admission until the pipeline is empty.
- Sits between multiple producer blocks and a common delay-matched consumer.

Parameters:
- DATA_WIDTH, 8, width of one data word.
- NUM_REQ, 4, number of requesters (>=2).
- NUM_REGS, 10, pipeline depth in cycles (>=1).
- ID_W (localparam), max(1, clog2(NUM_REQ)), requester ID width.
- CNT_W (localparam), clog2(NUM_REGS+1), in-flight counter width.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, NUM_REQ, per-requester word available.
- req_data, input, NUM_REQ*DATA_WIDTH, packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready, output, NUM_REQ, one-hot-or-zero grant; a word transfers when req_valid[i] && req_ready[i].
- drain, input, 1, request to stop admission and empty the pipeline.
- out_valid, output, 1, pipeline output word valid.
- out_data, output, DATA_WIDTH, pipeline output word.
- out_id, output, ID_W, requester index of out_data.
- busy, output, 1, in-flight count non-zero.
- drain_done, output, 1, one-cycle pulse when the drain completes.

Behaviour:
- Reset: all pipeline stages cleared (out_valid=0, out_data=0, out_id=0); count=0; busy=0; drain_done=0; state=RUN; RR pointer=NUM_REQ-1, so requester 0 has first priority.
- Pipeline: one shift_reg of width 1+ID_W+DATA_WIDTH carrying {valid,id,data}, driven by rst. Its input is {accept, grant_id, granted data}, or all-zero when nothing is accepted.
- Latency: a word accepted in cycle t appears on the out_* ports in cycle t+NUM_REGS, held for exactly 1 cycle.
- Arbiter, combinational on req_valid, pointer and state:
  - In RUN, search from pointer+1 (mod NUM_REQ) upward.
  - The first requester with req_valid high gets req_ready.
  - req_ready is all-zero when no requester is valid or state!=RUN.
  - req_ready never depends on out_* signals; the pipeline cannot stall.
- Pointer updates to the granted index on accept; otherwise it holds.
- In-flight count:
  - +1 on accept, -1 on out_valid, unchanged when both occur in the same cycle.
  - Never exceeds NUM_REGS; wrap is impossible.
- busy = (count != 0), registered alongside count.
- FSM:
  - RUN: admit normally. If drain=1, go to DRAIN (admission stops the same cycle drain is sampled high, i.e. req_ready is masked combinationally by drain in RUN).
  - DRAIN: no grants. When count==0, or count==1 && out_valid, go to DONE.
  - DONE: drain_done=1 for this single cycle. Next state is RUN if drain==0, else stay in HOLD (DONE is not re-pulsed).
  - HOLD: no grants; return to RUN when drain==0.
- drain asserted with an empty pipeline: RUN->DRAIN->DONE, so the pulse arrives 2 cycles after drain is sampled.
- drain deasserted mid-DRAIN: the drain still completes (DONE pulses), then returns to RUN.
- rst mid-operation: in-flight words are discarded (never emitted) and count returns to 0.
- Requester i holding req_valid with changing req_data: only the data present in the accept cycle is captured.

Optional Feature:
- Macro: SHIFT_REG_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins, and the RR pointer logic is removed.
- Undefined: round-robin as described above.
- FSM, latency, counting and drain behaviour are identical in both builds.

Test Plan:
- Reset, then single requester 2 sends 0x5A at cycle 0 -> out_valid=1, out_data=0x5A, out_id=2 at cycle 10; busy=1 during cycles 1..10 and 0 from cycle 11.
- All four req_valid held high for 8 cycles with data = 0x10+i -> grants in order 0,1,2,3,0,1,2,3, one per cycle; outputs emerge in the same order at cycles 10..17. With FIXED_PRIO_EN defined, all 8 grants go to requester 0.
- Requesters 1 and 3 valid continuously -> grants alternate 1,3,1,3; requesters 0 and 2 are never granted.
- Accept words on cycles 0..4, drain asserted at cycle 2 -> last accepted word is cycle 1; req_ready=0 from cycle 2; the last output appears at cycle 11; drain_done pulses once at cycle 12; grants resume once drain drops.
- drain pulsed for one cycle with an empty pipeline -> drain_done pulses exactly 2 cycles later and admission resumes the following cycle.
- rst asserted at cycle 5 after accepts on cycles 0..4 -> no out_valid ever appears for those words; busy=0 and count=0 from cycle 6; the first post-reset grant goes to requester 0.
